// File: rtl/reg_writeback_m_pkg.sv
`default_nettype none
// ============================================================================
// Module   : xm_wb_pkg
// Brief    : Shared types and constants for the XMakina writeback queue.
// Revision : 1.0 - initial release
// ============================================================================
package xm_wb_pkg;

  localparam int c_REG_WIDTH  = 16;
  localparam int c_REG_COUNT  = 8;
  localparam int c_ADDR_WIDTH = $clog2(c_REG_COUNT);
  localparam int c_HALF_WIDTH = c_REG_WIDTH / 2;

  localparam logic [1:0] WR_EN_WORD = 2'b11;
  localparam logic [1:0] WR_EN_BYTE = 2'b10;
  localparam logic [1:0] WR_EN_NONE = 2'b00;

  localparam logic [c_ADDR_WIDTH-1:0] PC_ADDR = c_ADDR_WIDTH'(7);

  typedef struct packed {
    logic [c_ADDR_WIDTH-1:0] addr;
    logic [c_REG_WIDTH-1:0]  data;
    logic                    byte_wr;
  } wb_entry_t;

  function automatic logic [c_REG_COUNT-1:0] addr_onehot(input logic [c_ADDR_WIDTH-1:0] addr);
    logic [c_REG_COUNT-1:0] v;
    v       = '0;
    v[addr] = 1'b1;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_writeback_m_if.sv
`default_nettype none
// ============================================================================
// Module   : reg_writeback_m_if
// Brief    : Request side, register-file write port and status of the queue.
// Revision : 1.0 - initial release
// ============================================================================
interface reg_writeback_m_if #(
  parameter int REG_WIDTH = 16,
  parameter int REG_COUNT = 8,
  parameter int DEPTH     = 4
);
  localparam int c_ADDR_W = $clog2(REG_COUNT);
  localparam int c_CNT_W  = $clog2(DEPTH) + 1;

  logic                 req_valid;
  logic                 req_ready;
  logic [c_ADDR_W-1:0]  req_addr;
  logic [REG_WIDTH-1:0] req_data;
  logic                 req_byte;
  logic                 wr_hold;
  logic                 flush;

  logic [1:0]           wr_en;
  logic [c_ADDR_W-1:0]  wr_addr;
  logic [REG_WIDTH-1:0] wr_data;
  logic [REG_COUNT-1:0] pending;
  logic [c_CNT_W-1:0]   count;
  logic                 full;
  logic                 empty;

  modport master (
    output req_valid, req_addr, req_data, req_byte, wr_hold, flush,
    input  req_ready, wr_en, wr_addr, wr_data, pending, count, full, empty
  );

  modport slave (
    input  req_valid, req_addr, req_data, req_byte, wr_hold, flush,
    output req_ready, wr_en, wr_addr, wr_data, pending, count, full, empty
  );
endinterface
`default_nettype wire

// File: rtl/reg_writeback_m_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_fifo_m
// Brief    : DEPTH-entry in-order FIFO of writeback entries with flush.
// Revision : 1.0 - initial release
// ============================================================================
module wb_fifo_m
  import xm_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wire logic                       clk,
  input  wire logic                       rst,
  input  wire logic                       push,
  input  wire wb_entry_t                  push_entry,
  input  wire logic                       pop,
  input  wire logic                       flush,
  output wb_entry_t                       head,
  output wb_entry_t                       slots [DEPTH],
  output logic      [DEPTH-1:0]           slot_vld,
  output logic      [$clog2(DEPTH):0]     count,
  output logic                            full,
  output logic                            empty
);
  localparam int c_PTR_W = $clog2(DEPTH);

  wb_entry_t            r_mem [DEPTH];
  logic [DEPTH-1:0]     r_vld;
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_PTR_W:0]     r_count;

  logic                 w_push;
  logic                 w_pop;

  // Guard locally so a misbehaving caller can never corrupt occupancy.
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_vld    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_vld    <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= push_entry;
        r_vld[r_wr_ptr] <= 1'b1;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_vld[r_rd_ptr] <= 1'b0;
        r_rd_ptr        <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign head     = r_mem[r_rd_ptr];
  assign slots    = r_mem;
  assign slot_vld = r_vld;
  assign count    = r_count;
  assign full     = (r_count == (c_PTR_W+1)'(DEPTH));
  assign empty    = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/reg_writeback_m.sv
`default_nettype none
// ============================================================================
// Module   : reg_writeback_m
// Brief    : In-order writeback queue driving the register file write port.
// Revision : 1.0 - initial release
// ============================================================================
module reg_writeback_m
  import xm_wb_pkg::*;
#(
  parameter int REG_WIDTH = c_REG_WIDTH,
  parameter int REG_COUNT = c_REG_COUNT,
  parameter int DEPTH     = 4
) (
  input wire logic          clk,
  input wire logic          rst,
  reg_writeback_m_if.slave  bus
);
  localparam int c_HALF = REG_WIDTH / 2;

  wb_entry_t              w_entry;
  wb_entry_t              w_head;
  wb_entry_t              w_slots [DEPTH];
  logic [DEPTH-1:0]       w_slot_vld;
  logic [$clog2(DEPTH):0] w_count;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_drain;
  logic [REG_COUNT-1:0]   w_slot_mask [DEPTH];
  logic [REG_COUNT-1:0]   w_pending;

  // No pass-through when full: a same-cycle drain does not open a slot.
  assign bus.req_ready = ~w_full & ~bus.flush;
  assign w_push        = bus.req_valid & bus.req_ready;
  assign w_drain       = ~w_empty & ~bus.wr_hold & ~bus.flush;

  assign w_entry.addr    = bus.req_addr;
  assign w_entry.data    = bus.req_data;
  assign w_entry.byte_wr = bus.req_byte;

  wb_fifo_m #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (w_push),
    .push_entry (w_entry),
    .pop        (w_drain),
    .flush      (bus.flush),
    .head       (w_head),
    .slots      (w_slots),
    .slot_vld   (w_slot_vld),
    .count      (w_count),
    .full       (w_full),
    .empty      (w_empty)
  );

  // R7 (PC_ADDR) gets no special treatment; the register file decodes it.
  always_comb begin
    bus.wr_en   = WR_EN_NONE;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    if (w_drain) begin
      bus.wr_addr = w_head.addr;
      if (w_head.byte_wr) begin
        bus.wr_en   = WR_EN_BYTE;
        bus.wr_data = {{(REG_WIDTH-c_HALF){1'b0}}, w_head.data[c_HALF-1:0]};
      end else begin
        bus.wr_en   = WR_EN_WORD;
        bus.wr_data = w_head.data;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_pending
      assign w_slot_mask[gi] = w_slot_vld[gi] ? addr_onehot(w_slots[gi].addr) : '0;
    end
  endgenerate

  always_comb begin
    w_pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_pending = w_pending | w_slot_mask[i];
    end
  end

  assign bus.pending = w_pending;
  assign bus.count   = w_count;
  assign bus.full    = w_full;
  assign bus.empty   = w_empty;

endmodule
`default_nettype wire

// File: tb/tb_reg_writeback_m.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_writeback_m
// Brief    : Directed self-checking bench for the writeback queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_writeback_m;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  reg_writeback_m_if #(.REG_WIDTH(16), .REG_COUNT(8), .DEPTH(4)) bus ();

  reg_writeback_m #(.REG_WIDTH(16), .REG_COUNT(8), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v, input int addr, input int data, input logic b);
    bus.req_valid = v;
    bus.req_addr  = 3'(addr);
    bus.req_data  = 16'(data);
    bus.req_byte  = b;
  endtask

  initial begin
    set_req(1'b0, 0, 0, 1'b0);
    bus.wr_hold = 1'b0;
    bus.flush   = 1'b0;
    repeat (2) step();
    rst = 1'b0;

    // Fill one entry, then hit rst between clock edges.
    bus.wr_hold = 1'b1;
    set_req(1'b1, 5, 16'h5555, 1'b0);
    #1;
    step();
    bus.req_valid = 1'b0;
    #1;
    chk("pre_rst_count",   32'(bus.count),   32'd1);
    chk("pre_rst_pending", 32'(bus.pending), 32'h20);
    chk("hold_wr_en",      32'(bus.wr_en),   32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_wr_en",   32'(bus.wr_en),     32'd0);
    chk("rst_pending", 32'(bus.pending),   32'd0);
    chk("rst_count",   32'(bus.count),     32'd0);
    chk("rst_empty",   32'(bus.empty),     32'd1);
    chk("rst_full",    32'(bus.full),      32'd0);
    chk("rst_ready",   32'(bus.req_ready), 32'd1);
    chk("rst_wr_addr", 32'(bus.wr_addr),   32'd0);
    chk("rst_wr_data", 32'(bus.wr_data),   32'd0);
    step();
    rst = 1'b0;
    bus.wr_hold = 1'b0;

    // Word write R3 = 0xBEEF
    set_req(1'b1, 3, 16'hBEEF, 1'b0);
    step();
    bus.req_valid = 1'b0;
    #1;
    chk("word_wr_en",   32'(bus.wr_en),   32'h3);
    chk("word_wr_addr", 32'(bus.wr_addr), 32'd3);
    chk("word_wr_data", 32'(bus.wr_data), 32'hBEEF);
    chk("word_pending", 32'(bus.pending), 32'h08);
    step();
    chk("word_pend_clr", 32'(bus.pending), 32'h0);
    chk("word_empty",    32'(bus.empty),   32'd1);
    chk("word_idle_en",  32'(bus.wr_en),   32'd0);

    // Byte write R2 = 0x12AB keeps only the low half
    set_req(1'b1, 2, 16'h12AB, 1'b1);
    step();
    bus.req_valid = 1'b0;
    #1;
    chk("byte_wr_en",   32'(bus.wr_en),   32'h2);
    chk("byte_wr_addr", 32'(bus.wr_addr), 32'd2);
    chk("byte_wr_data", 32'(bus.wr_data), 32'h00AB);
    step();

    // PC write drains like any other register
    set_req(1'b1, 7, 16'h0100, 1'b0);
    step();
    bus.req_valid = 1'b0;
    #1;
    chk("pc_wr_addr", 32'(bus.wr_addr), 32'd7);
    chk("pc_wr_data", 32'(bus.wr_data), 32'h0100);
    chk("pc_pending", 32'(bus.pending), 32'h80);
    step();

    // Fill under wr_hold, stall a fifth request, then drain in order
    bus.wr_hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      set_req(1'b1, i, 16'h1111 * i, 1'b0);
      step();
    end
    set_req(1'b1, 5, 16'h5555, 1'b0);
    #1;
    chk("fill_full",    32'(bus.full),      32'd1);
    chk("fill_ready",   32'(bus.req_ready), 32'd0);
    chk("fill_pending", 32'(bus.pending),   32'h1E);
    chk("fill_hold_en", 32'(bus.wr_en),     32'd0);
    step();
    chk("stall_count", 32'(bus.count), 32'd4);
    bus.req_valid = 1'b0;
    bus.wr_hold   = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_count", 32'(bus.count),   32'(4 - i));
      chk("drain_addr",  32'(bus.wr_addr), 32'(i + 1));
      chk("drain_data",  32'(bus.wr_data), 32'(16'h1111 * (i + 1)));
      step();
      #1;
    end
    chk("drain_done_count", 32'(bus.count), 32'd0);
    chk("drain_done_empty", 32'(bus.empty), 32'd1);
    set_req(1'b1, 5, 16'h5555, 1'b0);
    step();
    bus.req_valid = 1'b0;
    #1;
    chk("fifth_addr", 32'(bus.wr_addr), 32'd5);
    chk("fifth_data", 32'(bus.wr_data), 32'h5555);
    step();

    // Flush with a simultaneous request
    bus.wr_hold = 1'b1;
    for (int i = 5; i <= 7; i++) begin
      set_req(1'b1, i, 16'h0F00 + i, 1'b0);
      step();
    end
    bus.req_valid = 1'b0;
    #1;
    chk("pre_flush_count",   32'(bus.count),   32'd3);
    chk("pre_flush_pending", 32'(bus.pending), 32'hE0);
    set_req(1'b1, 0, 16'h0F0F, 1'b0);
    bus.flush = 1'b1;
    #1;
    chk("flush_ready", 32'(bus.req_ready), 32'd0);
    step();
    bus.flush     = 1'b0;
    bus.req_valid = 1'b0;
    bus.wr_hold   = 1'b0;
    #1;
    chk("flush_count",   32'(bus.count),   32'd0);
    chk("flush_pending", 32'(bus.pending), 32'd0);
    chk("flush_wr_en",   32'(bus.wr_en),   32'd0);
    chk("flush_empty",   32'(bus.empty),   32'd1);

    // Push and pop together at count 2, wrapping pointers several times
    bus.wr_hold = 1'b1;
    for (int k = 0; k < 2; k++) begin
      set_req(1'b1, k % 8, 16'hA000 + k, 1'b0);
      step();
    end
    bus.wr_hold = 1'b0;
    for (int k = 0; k < 10; k++) begin
      set_req(1'b1, (k + 2) % 8, 16'hA000 + k + 2, 1'b0);
      #1;
      chk("pp_count", 32'(bus.count),   32'd2);
      chk("pp_addr",  32'(bus.wr_addr), 32'(k % 8));
      chk("pp_data",  32'(bus.wr_data), 32'(16'hA000 + k));
      step();
    end
    bus.req_valid = 1'b0;
    #1;
    for (int k = 10; k < 12; k++) begin
      chk("tail_addr", 32'(bus.wr_addr), 32'(k % 8));
      chk("tail_data", 32'(bus.wr_data), 32'(16'hA000 + k));
      step();
      #1;
    end
    chk("final_empty", 32'(bus.empty), 32'd1);
    chk("final_wr_en", 32'(bus.wr_en), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
